// File: rtl/spi_txn_arbiter_if.sv
// Requester-side and SPI-engine-side signals of the transaction arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/engine side.
interface spi_txn_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   resp_valid;
  logic [7:0]         resp_data;
  logic               resp_err;
  logic               eng_tx_start;
  logic               eng_rx_start;
  logic [7:0]         eng_tx_data;
  logic [7:0]         eng_rx_data;
  logic               eng_rx_valid;
  logic               eng_tx_done;
  logic [N_REQ-1:0]   cs_n;
  logic               busy;

  modport slave (
    input  req_valid, req_data, eng_rx_data, eng_rx_valid, eng_tx_done,
    output req_ready, resp_valid, resp_data, resp_err,
           eng_tx_start, eng_rx_start, eng_tx_data, cs_n, busy
  );

  modport master (
    output req_valid, req_data, eng_rx_data, eng_rx_valid, eng_tx_done,
    input  req_ready, resp_valid, resp_data, resp_err,
           eng_tx_start, eng_rx_start, eng_tx_data, cs_n, busy
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one byte-wide SPI engine among N_REQ requesters,
// with per-requester chip select, setup/hold timing and a completion timeout.
module spi_txn_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_txn_arbiter_if.slave      bus
);
  localparam int IdxW = $clog2(N_REQ);
  localparam int CntW = $clog2(TIMEOUT + CS_SETUP + CS_HOLD);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStart,
    StWait,
    StHold,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [7:0]      txData_q, txData_d;
  logic [7:0]      rxData_q, rxData_d;
  logic            rxSeen_q, rxSeen_d;
  logic            txSeen_q, txSeen_d;
  logic            err_q, err_d;

  logic            found;
  logic [IdxW-1:0] pick;
  logic [IdxW-1:0] candIdx;
  logic            rxNow, txNow;
  logic [N_REQ-1:0] reqReady, respValid, csN;
  logic [7:0]      respData;
  logic            respErr, startPulse;

  // Search upward from the requester after the last one served, wrapping around.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    candIdx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      candIdx = IdxW'((int'(last_q) + i) % N_REQ);
      if (!found && bus.req_valid[candIdx]) begin
        found = 1'b1;
        pick  = candIdx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    txData_d   = txData_q;
    rxData_d   = rxData_q;
    rxSeen_d   = rxSeen_q;
    txSeen_d   = txSeen_q;
    err_d      = err_q;
    reqReady   = '0;
    respValid  = '0;
    respData   = '0;
    respErr    = 1'b0;
    startPulse = 1'b0;
    csN        = '1;
    rxNow      = rxSeen_q | bus.eng_rx_valid;
    txNow      = txSeen_q | bus.eng_tx_done;

    case (state_q)
      StIdle: begin
        if (found) begin
          reqReady[pick] = 1'b1;
          owner_d        = pick;
          txData_d       = bus.req_data[8*pick +: 8];
          cnt_d          = '0;
          state_d        = StSetup;
        end
      end
      StSetup: begin
        csN[owner_q] = 1'b0;
        if (cnt_q == CntW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = StStart;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStart: begin
        csN[owner_q] = 1'b0;
        startPulse   = 1'b1;
        cnt_d        = '0;
        state_d      = StWait;
      end
      StWait: begin
        csN[owner_q] = 1'b0;
        if (bus.eng_rx_valid && !rxSeen_q) begin
          rxSeen_d = 1'b1;
          rxData_d = bus.eng_rx_data;
        end
        if (bus.eng_tx_done) begin
          txSeen_d = 1'b1;
        end
        // Completion is checked before the timeout so a last-cycle finish is not flagged.
        if (rxNow && txNow) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StHold;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        csN[owner_q] = 1'b0;
        if (cnt_q == CntW'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        respValid[owner_q] = 1'b1;
        respData           = err_q ? 8'h00 : rxData_q;
        respErr            = err_q;
        last_d             = owner_q;
        rxSeen_d           = 1'b0;
        txSeen_d           = 1'b0;
        rxData_d           = '0;
        err_d              = 1'b0;
        cnt_d              = '0;
        state_d            = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Priority starts at requester 0 because the pointer resets to the last index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      owner_q  <= '0;
      last_q   <= IdxW'(N_REQ - 1);
      txData_q <= '0;
      rxData_q <= '0;
      rxSeen_q <= 1'b0;
      txSeen_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      txData_q <= txData_d;
      rxData_q <= rxData_d;
      rxSeen_q <= rxSeen_d;
      txSeen_q <= txSeen_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready    = reqReady;
  assign bus.resp_valid   = respValid;
  assign bus.resp_data    = respData;
  assign bus.resp_err     = respErr;
  assign bus.eng_tx_start = startPulse;
  assign bus.eng_rx_start = startPulse;
  assign bus.eng_tx_data  = txData_q;
  assign bus.cs_n         = csN;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: a transaction-timeline model checked every
// cycle, a behavioural SPI engine, directed scenarios and a randomized soak.
module tb_spi_txn_arbiter;
  localparam int N     = 4;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_txn_arbiter_if #(.N_REQ(N)) bus ();

  spi_txn_arbiter #(
    .N_REQ(N), .CS_SETUP(SETUP), .CS_HOLD(HOLD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  int         grantIdx[$];
  int         grantCyc[$];
  int         respIdx[$];
  int         respCyc[$];
  logic [7:0] respByte[$];
  logic       respErrQ[$];
  logic [7:0] startTx[$];
  int         csLowCnt = 0;

  int         engMode  = 0;
  int         fixTx    = 8;
  int         fixRx    = 8;
  logic [7:0] fixByte  = 8'h00;
  bit         fixLevel = 1'b0;
  int         skipArms = 0;
  bit         forceRx  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int oneHotIdx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Timeline model: a grant at cycle g fixes the start cycle; completion or timeout
  // fixes the response cycle; chip select is low strictly between grant and response.
  initial begin
    bit         mBusy;
    int         mOwner, mLast, tStart, tDone, c;
    logic [7:0] mTx, rxByte, expTx, expData;
    bit         rxSeen, txSeen, mErr, expStart, expBusy, expErr;
    logic [N-1:0] expReady, expResp, expCs;
    mBusy = 0; mOwner = 0; mLast = N - 1; mTx = 0; tStart = 0; tDone = -1;
    rxSeen = 0; txSeen = 0; mErr = 0; rxByte = 0;
    forever begin
      @(negedge clk);
      cyc++;
      expReady = '0; expResp = '0; expCs = '1; expStart = 0; expBusy = 0;
      expData = 8'h00; expErr = 0;
      if (!rst_n) begin
        mBusy = 0; mLast = N - 1; mTx = 8'h00;
        expTx = 8'h00;
      end else begin
        expTx = mTx;
        if (!mBusy) begin
          for (int i = 1; i <= N; i++) begin
            c = (mLast + i) % N;
            if (expReady == '0 && bus.req_valid[c]) begin
              expReady[c] = 1'b1;
              mOwner = c;
            end
          end
          if (expReady != '0) begin
            mBusy = 1; mTx = bus.req_data[8*mOwner +: 8];
            tStart = cyc + 1 + SETUP; tDone = -1;
            rxSeen = 0; txSeen = 0; mErr = 0; rxByte = 8'h00;
          end
        end else begin
          expBusy = 1;
          if (cyc == tDone) begin
            expResp[mOwner] = 1'b1;
            expData = mErr ? 8'h00 : rxByte;
            expErr = mErr;
            mBusy = 0; mLast = mOwner;
          end else begin
            expCs[mOwner] = 1'b0;
            expStart = (cyc == tStart);
            if (cyc > tStart && tDone < 0) begin
              if (bus.eng_rx_valid && !rxSeen) begin
                rxSeen = 1; rxByte = bus.eng_rx_data;
              end
              if (bus.eng_tx_done) txSeen = 1;
              if (rxSeen && txSeen) tDone = cyc + HOLD + 1;
              else if (cyc - tStart - 1 == TMO - 1) begin
                mErr = 1; tDone = cyc + HOLD + 1;
              end
            end
          end
        end
      end
      checkOutput("req_ready", bus.req_ready, expReady);
      checkOutput("resp_valid", bus.resp_valid, expResp);
      checkOutput("resp_data", bus.resp_data, expData);
      checkOutput("resp_err", bus.resp_err, expErr);
      checkOutput("eng_tx_start", bus.eng_tx_start, expStart);
      checkOutput("eng_rx_start", bus.eng_rx_start, expStart);
      checkOutput("eng_tx_data", bus.eng_tx_data, expTx);
      checkOutput("cs_n", bus.cs_n, expCs);
      checkOutput("busy", bus.busy, expBusy);
      if (rst_n) begin
        if (bus.req_ready != '0) begin
          grantIdx.push_back(oneHotIdx(bus.req_ready));
          grantCyc.push_back(cyc);
        end
        if (bus.resp_valid != '0) begin
          respIdx.push_back(oneHotIdx(bus.resp_valid));
          respCyc.push_back(cyc);
          respByte.push_back(bus.resp_data);
          respErrQ.push_back(bus.resp_err);
        end
        if (bus.eng_tx_start) startTx.push_back(bus.eng_tx_data);
        if (bus.cs_n == 4'b1101) csLowCnt++;
      end
    end
  end

  // Behavioural engine: arms on the start pulse and raises rx_valid/tx_done a set
  // number of cycles later, as pulses or 4-cycle levels.
  initial begin
    bit         armed, lvl, rx, tx;
    int         k, dTx, dRx;
    logic [7:0] b;
    armed = 0; lvl = 0; k = 0; dTx = -1; dRx = -1; b = 8'h00;
    bus.eng_rx_valid = 1'b0;
    bus.eng_tx_done  = 1'b0;
    bus.eng_rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed = 0;
      end else if (bus.eng_tx_start) begin
        armed = 1; k = 0;
        if (engMode == 1) begin
          dTx = $urandom_range(1, 20);
          dRx = $urandom_range(1, 20);
          lvl = 1'($urandom_range(0, 1));
          b   = 8'($urandom);
          if ($urandom_range(0, 7) == 0) dRx = -1;
        end else begin
          dTx = fixTx; dRx = fixRx; lvl = fixLevel; b = fixByte;
        end
        if (skipArms > 0) begin
          skipArms--; dTx = -1; dRx = -1;
        end
      end
      @(posedge clk);
      #2;
      if (armed) k++;
      rx = armed && dRx >= 0 && (lvl ? (k >= dRx && k < dRx + 4) : (k == dRx));
      tx = armed && dTx >= 0 && (lvl ? (k >= dTx && k < dTx + 4) : (k == dTx));
      bus.eng_rx_valid = rx || forceRx;
      bus.eng_tx_done  = tx;
      bus.eng_rx_data  = rx ? b : 8'($urandom);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [8*N-1:0] data);
    bus.req_valid = valid;
    bus.req_data  = data;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic clearLogs();
    grantIdx.delete(); grantCyc.delete(); respIdx.delete(); respCyc.delete();
    respByte.delete(); respErrQ.delete(); startTx.delete();
    csLowCnt = 0;
  endtask

  task automatic waitGrant(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (grantIdx.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    checkOutput(name, (grantIdx.size() >= n), 1);
  endtask

  task automatic waitResp(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (respIdx.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    checkOutput(name, (respIdx.size() >= n), 1);
  endtask

  initial begin
    applyStimulus('0, '0);
    tick(3);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_cs_n", bus.cs_n, 4'hF);
    checkOutput("reset_tx_data", bus.eng_tx_data, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // Single request from requester 1.
    clearLogs();
    engMode = 0; fixTx = 8; fixRx = 8; fixByte = 8'h3C; fixLevel = 0;
    applyStimulus(4'b0010, 32'h0000_A500);
    waitGrant(1, 50, "t1_grant_seen");
    applyStimulus('0, 32'h0000_A500);
    waitResp(1, 100, "t1_resp_seen");
    if (grantIdx.size() >= 1 && respIdx.size() >= 1 && startTx.size() >= 1) begin
      checkOutput("t1_grant_idx", grantIdx[0], 1);
      checkOutput("t1_resp_idx", respIdx[0], 1);
      checkOutput("t1_resp_data", respByte[0], 8'h3C);
      checkOutput("t1_resp_err", respErrQ[0], 0);
      checkOutput("t1_latency", respCyc[0] - grantCyc[0], 14);
      checkOutput("t1_cs_low_cycles", csLowCnt, 13);
      checkOutput("t1_tx_data", startTx[0], 8'hA5);
    end

    // Round-robin with all requesters held high.
    applyReset();
    clearLogs();
    engMode = 1;
    applyStimulus(4'hF, 32'h4433_2211);
    waitResp(5, 400, "t2_resp_seen");
    applyStimulus('0, 32'h4433_2211);
    tick(3);
    checkOutput("t2_grant_count", grantIdx.size(), 5);
    if (grantIdx.size() >= 5) begin
      checkOutput("t2_grant0", grantIdx[0], 0);
      checkOutput("t2_grant1", grantIdx[1], 1);
      checkOutput("t2_grant2", grantIdx[2], 2);
      checkOutput("t2_grant3", grantIdx[3], 3);
      checkOutput("t2_grant4", grantIdx[4], 0);
    end

    // Split completion: tx_done in WAIT cycle 3, rx_valid in WAIT cycle 9.
    clearLogs();
    engMode = 0; fixTx = 4; fixRx = 10; fixByte = 8'h5A; fixLevel = 0;
    applyStimulus(4'b0100, 32'h0077_0000);
    waitGrant(1, 50, "t3_grant_seen");
    applyStimulus('0, 32'h0077_0000);
    waitResp(1, 100, "t3_resp_seen");
    if (respIdx.size() >= 1 && grantIdx.size() >= 1 && startTx.size() >= 1) begin
      checkOutput("t3_latency", respCyc[0] - grantCyc[0], 16);
      checkOutput("t3_resp_data", respByte[0], 8'h5A);
      checkOutput("t3_resp_idx", respIdx[0], 2);
      checkOutput("t3_tx_data", startTx[0], 8'h77);
    end

    // Timeout on requester 3, then requester 0 is served normally.
    clearLogs();
    skipArms = 1; fixTx = 3; fixRx = 5; fixByte = 8'h99;
    applyStimulus(4'b1001, 32'hD000_00C0);
    waitGrant(1, 50, "t4_grant_seen");
    applyStimulus(4'b0001, 32'hD000_00C0);
    waitGrant(2, 100, "t4_grant2_seen");
    applyStimulus('0, 32'hD000_00C0);
    waitResp(2, 100, "t4_resp_seen");
    if (grantIdx.size() >= 2 && respIdx.size() >= 2) begin
      checkOutput("t4_grant0", grantIdx[0], 3);
      checkOutput("t4_grant1", grantIdx[1], 0);
      checkOutput("t4_err", respErrQ[0], 1);
      checkOutput("t4_err_data", respByte[0], 8'h00);
      checkOutput("t4_timeout_latency", respCyc[0] - grantCyc[0], 22);
      checkOutput("t4_next_grant_gap", grantCyc[1] - respCyc[0], 1);
      checkOutput("t4_second_ok", respErrQ[1], 0);
      checkOutput("t4_second_data", respByte[1], 8'h99);
    end

    // Reset during WAIT aborts silently; afterwards requester 0 beats requester 2.
    clearLogs();
    skipArms = 1;
    applyStimulus(4'b0010, 32'h0000_1100);
    waitGrant(1, 50, "t5_grant_seen");
    applyStimulus('0, 32'h0000_1100);
    tick(8);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_cs_n", bus.cs_n, 4'hF);
    checkOutput("t5_rst_busy", bus.busy, 0);
    checkOutput("t5_rst_resp", bus.resp_valid, 4'h0);
    tick(2);
    rst_n = 1'b1;
    checkOutput("t5_no_resp", respIdx.size(), 0);
    clearLogs();
    skipArms = 0; fixTx = 5; fixRx = 5; fixByte = 8'h42;
    applyStimulus(4'b0101, 32'h0032_0031);
    waitGrant(1, 50, "t5_grant2_seen");
    applyStimulus('0, 32'h0032_0031);
    waitResp(1, 100, "t5_resp_seen");
    if (grantIdx.size() >= 1 && respIdx.size() >= 1) begin
      checkOutput("t5_winner", grantIdx[0], 0);
      checkOutput("t5_resp_data", respByte[0], 8'h42);
    end

    // One-cycle withdrawal from requester 3 while busy, then a stray rx_valid in IDLE.
    clearLogs();
    applyStimulus(4'b0010, 32'h0000_2200);
    waitGrant(1, 50, "t6_grant_seen");
    applyStimulus(4'b1000, 32'h3300_0000);
    tick(1);
    applyStimulus('0, 32'h0000_0000);
    waitResp(1, 100, "t6_resp_seen");
    tick(3);
    checkOutput("t6_grant_count", grantIdx.size(), 1);
    forceRx = 1'b1;
    tick(1);
    forceRx = 1'b0;
    tick(2);
    checkOutput("t6_idle_after_stray", bus.busy, 0);
    clearLogs();
    fixTx = 2; fixRx = 10; fixByte = 8'h6E;
    applyStimulus(4'b0100, 32'h0055_0000);
    waitGrant(1, 50, "t6_grant2_seen");
    applyStimulus('0, 32'h0055_0000);
    waitResp(1, 100, "t6_resp2_seen");
    if (grantIdx.size() >= 1 && respIdx.size() >= 1) begin
      checkOutput("t6_latency", respCyc[0] - grantCyc[0], 16);
      checkOutput("t6_resp_data", respByte[0], 8'h6E);
    end

    // Randomized soak: requests toggle every cycle, engine timing and levels random.
    engMode = 1;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom), 32'($urandom));
      tick(1);
    end
    applyStimulus('0, '0);
    for (int i = 0; i < 100 && bus.busy; i++) tick(1);
    tick(2);
    checkOutput("final_busy", bus.busy, 0);
    checkOutput("final_cs_n", bus.cs_n, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
